// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and interrupt state type for the input-side peripheral
package io_pkg;

  localparam int IO_DATA_W          = 8;
  localparam int IO_DEFAULT_DEPTH   = 4;
  localparam int IO_DEFAULT_HOLDOFF = 8;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_TAKE,
    HOLD
  } irq_state_t;

endpackage

// File: rtl/io_in_fifo.sv
// rtl/io_in_fifo.sv - byte FIFO with registered count; head reads 0 when empty
// Caller guarantees no push when full and no pop when empty.
module io_in_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = IO_DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [IO_DATA_W-1:0]       i_data,
  input  logic                       i_pop,
  output logic [IO_DATA_W-1:0]       o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IO_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  // Gating on the registered count keeps stale storage off the port.
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/io_in_ctrl.sv
// rtl/io_in_ctrl.sv - producer handshake, overflow flag and interrupt FSM in front of the core
// Optional build macro: IO_IN_IRQ_EN enables the interrupt FSM; otherwise interrupt is tied low.
module io_in_ctrl
  import io_pkg::*;
#(
  parameter int DEPTH   = IO_DEFAULT_DEPTH,
  parameter int HOLDOFF = IO_DEFAULT_HOLDOFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_ext_valid,
  input  logic [IO_DATA_W-1:0]   i_ext_data,
  output logic                   o_ext_ready,
  input  logic                   i_in_take,
  output logic [IO_DATA_W-1:0]   o_input_port,
  output logic                   o_interrupt,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_overflow,
  input  logic                   i_clr_overflow
);

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic r_overflow;

  assign o_ext_ready = !w_full;
  assign w_push      = i_ext_valid && !w_full;
  assign w_pop       = i_in_take && !w_empty;

  io_in_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (i_ext_data),
    .i_pop   (w_pop),
    .o_head  (o_input_port),
    .o_count (o_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (i_ext_valid && w_full) begin
      r_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_overflow = r_overflow;

`ifdef IO_IN_IRQ_EN
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

  irq_state_t r_state;
  irq_state_t w_state_nxt;
  logic [7:0] r_hold;
  logic [7:0] w_hold_nxt;
  logic       r_irq;
  logic       w_irq_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_irq_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = PULSE;
      end
      // A pop while the pulse is still up already consumes the request.
      PULSE, WAIT_TAKE: begin
        if (w_pop) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = HOLD_LOAD;
        end else begin
          w_state_nxt = WAIT_TAKE;
        end
      end
      HOLD: begin
        if (r_hold == 8'd0) w_state_nxt = IDLE;
        else                w_hold_nxt  = r_hold - 8'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_irq_nxt = (w_state_nxt == PULSE);
  end

  assign o_interrupt = r_irq;
`else
  assign o_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_io_in_ctrl.sv
// tb/tb_io_in_ctrl.sv - scoreboard bench for io_in_ctrl with DEPTH=4, HOLDOFF=3
module tb_io_in_ctrl;

`ifdef IO_IN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef struct {
    logic       rdy;
    logic [7:0] port;
    int         cnt;
    logic       ovf;
    logic       irq;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ext_valid = 1'b0;
  logic [7:0] ext_data = 8'h00;
  logic       ext_ready;
  logic       in_take = 1'b0;
  logic [7:0] input_port;
  logic       interrupt;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  always #5 clk = ~clk;

  io_in_ctrl #(
    .DEPTH   (4),
    .HOLDOFF (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_ext_valid    (ext_valid),
    .i_ext_data     (ext_data),
    .o_ext_ready    (ext_ready),
    .i_in_take      (in_take),
    .o_input_port   (input_port),
    .o_interrupt    (interrupt),
    .o_fifo_count   (fifo_count),
    .o_overflow     (overflow),
    .i_clr_overflow (clr_overflow)
  );

  // Inputs are applied at negedge and the expected post-edge state is queued.
  task automatic v(input bit rst, input bit vld, input logic [7:0] d, input bit tk, input bit cl,
                   input bit er, input logic [7:0] ep, input int ec, input bit eo, input bit ei);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    ext_valid    = vld;
    ext_data     = d;
    in_take      = tk;
    clr_overflow = cl;
    e.rdy  = er;
    e.port = ep;
    e.cnt  = ec;
    e.ovf  = eo;
    e.irq  = ei & IRQ_EN;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (ext_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL vec%0d ext_ready got %b want %b", n_vec, ext_ready, e.rdy);
      end
      if (input_port !== e.port) begin
        n_bad++;
        $display("FAIL vec%0d input_port got %h want %h", n_vec, input_port, e.port);
      end
      if (fifo_count !== 3'(e.cnt)) begin
        n_bad++;
        $display("FAIL vec%0d fifo_count got %0d want %0d", n_vec, fifo_count, e.cnt);
      end
      if (overflow !== e.ovf) begin
        n_bad++;
        $display("FAIL vec%0d overflow got %b want %b", n_vec, overflow, e.ovf);
      end
      if (interrupt !== e.irq) begin
        n_bad++;
        $display("FAIL vec%0d interrupt got %b want %b", n_vec, interrupt, e.irq);
      end
    end
  end

  initial begin
    // reset, single push, one-cycle pulse, take, holdoff
    v(1, 0, 8'h00, 0, 0,  1, 8'h00, 0, 0, 0);
    v(0, 1, 8'h5A, 0, 0,  1, 8'h5A, 1, 0, 0);
    v(0, 0, 8'h00, 0, 0,  1, 8'h5A, 1, 0, 1);
    v(0, 0, 8'h00, 0, 0,  1, 8'h5A, 1, 0, 0);
    v(0, 0, 8'h00, 0, 0,  1, 8'h5A, 1, 0, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) v(0, 0, 8'h00, 0, 0,  1, 8'h00, 0, 0, 0);
    // fill, overflow drop, drain in order, pop while empty, clear
    v(0, 1, 8'h11, 0, 0,  1, 8'h11, 1, 0, 0);
    v(0, 1, 8'h22, 0, 0,  1, 8'h11, 2, 0, 1);
    v(0, 1, 8'h33, 0, 0,  1, 8'h11, 3, 0, 0);
    v(0, 1, 8'h44, 0, 0,  0, 8'h11, 4, 0, 0);
    v(0, 1, 8'h55, 0, 0,  0, 8'h11, 4, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'h22, 3, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'h33, 2, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'h44, 1, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'h00, 0, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'h00, 0, 1, 0);
    v(0, 0, 8'h00, 0, 1,  1, 8'h00, 0, 0, 0);
    // full with simultaneous offer and pop, then holdoff and second pulse
    v(0, 1, 8'hA1, 0, 0,  1, 8'hA1, 1, 0, 0);
    v(0, 1, 8'hA2, 0, 0,  1, 8'hA1, 2, 0, 1);
    v(0, 1, 8'hA3, 0, 0,  1, 8'hA1, 3, 0, 0);
    v(0, 1, 8'hA4, 0, 0,  0, 8'hA1, 4, 0, 0);
    v(0, 1, 8'h55, 1, 0,  1, 8'hA2, 3, 1, 0);
    v(0, 1, 8'hB5, 0, 0,  0, 8'hA2, 4, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'hA3, 3, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'hA4, 2, 1, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'hB5, 1, 1, 0);
    v(0, 0, 8'h00, 0, 0,  1, 8'hB5, 1, 1, 1);
    for (int i = 0; i < 51; i++) v(0, 0, 8'h00, 0, 0,  1, 8'hB5, 1, 1, 0);
    // clear, refill, clear racing a new overflow
    v(0, 0, 8'h00, 0, 1,  1, 8'hB5, 1, 0, 0);
    v(0, 1, 8'hC1, 0, 0,  1, 8'hB5, 2, 0, 0);
    v(0, 1, 8'hC2, 0, 0,  1, 8'hB5, 3, 0, 0);
    v(0, 1, 8'hC3, 0, 0,  0, 8'hB5, 4, 0, 0);
    v(0, 1, 8'h66, 0, 1,  0, 8'hB5, 4, 1, 0);
    v(0, 0, 8'h00, 0, 1,  0, 8'hB5, 4, 0, 0);
    v(0, 0, 8'h00, 1, 0,  1, 8'hC1, 3, 0, 0);
    // reset with three queued, then pop during the pulse itself
    v(1, 0, 8'h00, 0, 0,  1, 8'h00, 0, 0, 0);
    v(0, 0, 8'h00, 0, 0,  1, 8'h00, 0, 0, 0);
    v(0, 1, 8'h77, 0, 0,  1, 8'h77, 1, 0, 0);
    v(0, 0, 8'h00, 0, 0,  1, 8'h77, 1, 0, 1);
    v(0, 0, 8'h00, 1, 0,  1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) v(0, 0, 8'h00, 0, 0,  1, 8'h00, 0, 0, 0);
    v(0, 1, 8'h88, 0, 0,  1, 8'h88, 1, 0, 0);
    v(0, 0, 8'h00, 0, 0,  1, 8'h88, 1, 0, 1);
    v(0, 0, 8'h00, 0, 0,  1, 8'h88, 1, 0, 0);
    @(negedge clk);
    ext_valid = 1'b0;
    in_take   = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain %0d expectations left want 0", exp_q.size());
    end
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        repeat (5000) @(posedge clk);
        n_bad++;
        $display("FAIL timeout done got 0 want 1");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
